// File: rtl/pdm_decimator.sv
// pdm_decimator: 3rd-order CIC decimator (differential delay 1) that turns the
// 2-bit delta-sigma PDM stream into 16-bit signed PCM, one sample per DECIM
// clocks with a single-cycle strobe. The first three comb results are
// discarded as filter transient.
module pdm_decimator #(
  parameter int DECIM = 8            // 4, 8 or 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pdm,
  output logic [15:0] pcm,
  output logic        pcm_valid
);

  localparam int LOG2 = $clog2(DECIM);
  localparam int W    = 3 + 3 * LOG2;   // CIC register growth: 3 + N*log2(R)
  localparam int PH_W = LOG2;
  localparam int SH   = 16 - W;         // left-justify into the 16-bit word

  // Input code to odd-level signed value: 00:-3 01:-1 10:+1 11:+3
  logic [2:0]   x;
  logic [W-1:0] x_ext;

  logic [W-1:0] i1_q, i2_q, i3_q;
  logic [W-1:0] i1_d, i2_d, i3_d;
  logic [W-1:0] d1_q, d2_q, d3_q;
  logic [W-1:0] c1, c2, c3;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [1:0]   warm_q;
  logic         comb_evt;
  logic         emit;
  logic [15:0]  pcm_q, pcm_d;
  logic         pcm_valid_q;

  assign x     = {~pdm[1], pdm[0], 1'b1};
  assign x_ext = {{(W-3){x[2]}}, x};

  // Integrator chain is pipelined: each stage adds the previous-cycle value of
  // the stage before it. Wrap-around is intentional (modular CIC arithmetic).
  always_comb begin
    i1_d = i1_q + x_ext;
    i2_d = i2_q + i1_q;
    i3_d = i3_q + i2_q;
  end

  // Phase counter and comb stages, all from pre-edge register values
  always_comb begin
    comb_evt = (ph_q == PH_W'(DECIM - 1));
    ph_d     = comb_evt ? '0 : ph_q + 1'b1;
    c1       = i3_q - d1_q;
    c2       = c1 - d2_q;
    c3       = c2 - d3_q;
    emit     = comb_evt && (warm_q == 2'd3);
    pcm_d    = {c3, {SH{1'b0}}};
  end

  // Integrators advance on every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      i3_q <= i3_d;
    end
  end

  // Decimation phase and warm-up counter (saturates at 3 comb events)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= '0;
      warm_q <= 2'd0;
    end else begin
      ph_q <= ph_d;
      if (comb_evt && warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Comb delay registers load only on the decimated phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else if (comb_evt) begin
      d1_q <= i3_q;
      d2_q <= c1;
      d3_q <= c2;
    end
  end

  // Registered PCM output: holds between strobes, strobe lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_q       <= 16'h0000;
      pcm_valid_q <= 1'b0;
    end else begin
      pcm_valid_q <= emit;
      if (emit) pcm_q <= pcm_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator with DECIM=8. Expected values are the
// hand-derived CIC steady-state levels (x * 8^3 << 4).
module tb_pdm_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pdm = 2'b11;
  logic [15:0] pcm;
  logic        pcm_valid;

  int checks = 0;
  int errors = 0;

  pdm_decimator #(.DECIM(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pdm       (pdm),
    .pcm       (pcm),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Release reset mid-cycle so that the next rising edge is edge 1
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Assert reset between edges and check that outputs clear with no clock
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk16({tag, "_pcm"}, pcm, 16'h0000);
    chk1({tag, "_vld"}, pcm_valid, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  // Run edges 1..nedges after reset release; strobes expected at edges 32,40,..
  // pcm must be 0 before the first strobe and exp afterwards (held).
  task automatic run_stream(input string tag, input int nedges, input bit alt,
                            input logic [15:0] exp);
    logic expv;
    for (int e = 1; e <= nedges; e++) begin
      @(posedge clk);
      #1;
      expv = (e >= 32) && (e % 8 == 0);
      chk1($sformatf("%s_vld_e%0d", tag, e), pcm_valid, expv);
      chk16($sformatf("%s_pcm_e%0d", tag, e), pcm, (e >= 32) ? exp : 16'h0000);
      if (alt) pdm = ~pdm;   // 01 <-> 10
    end
  endtask

  initial begin
    // Held in reset with clock running
    pdm   = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk16("rst_pcm", pcm, 16'h0000);
    chk1("rst_vld", pcm_valid, 1'b0);

    // Positive full scale; stop right after the strobe at edge 40
    release_reset();
    run_stream("pos", 40, 1'b0, 16'h6000);
    // Strobe is high now; reset must drop it and pcm immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk16("async_rst_pcm", pcm, 16'h0000);
    chk1("async_rst_vld", pcm_valid, 1'b0);
    repeat (2) @(negedge clk);

    // Negative full scale
    pdm = 2'b00;
    release_reset();
    run_stream("neg", 56, 1'b0, 16'hA000);

    // Low positive level
    async_reset("rst2");
    pdm = 2'b10;
    release_reset();
    run_stream("low", 56, 1'b0, 16'h2000);

    // Idle pattern: alternating 01/10 decodes to exactly zero
    async_reset("rst3");
    pdm = 2'b01;
    release_reset();
    run_stream("idle", 64, 1'b1, 16'h0000);

    // Mid-stream reset: 50 edges of +FS, reset 3 cycles, then -FS
    async_reset("rst4");
    pdm = 2'b11;
    release_reset();
    run_stream("mid_pos", 50, 1'b0, 16'h6000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk16("mid_rst_pcm", pcm, 16'h0000);
    chk1("mid_rst_vld", pcm_valid, 1'b0);
    repeat (2) @(negedge clk);
    pdm = 2'b00;
    release_reset();
    run_stream("mid_neg", 56, 1'b0, 16'hA000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
